// File: rtl/ps2_cmd_scheduler.sv
// Shares one PS/2 transmitter between two command requesters and sequences ACK/RESEND/timeout.
// Optional macro PS2_SCHED_RR_EN: round-robin tie break instead of fixed req0 priority.
module ps2_cmd_scheduler #(
  parameter int CLKFREQ        = 50_000_000,
  parameter int ACK_TIMEOUT_MS = 20,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       acc0,
  output logic       acc1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       fwd_valid,
  output logic [7:0] fwd_data,
  output logic       busy
);

  localparam int TO_CYC = (CLKFREQ / 1000) * ACK_TIMEOUT_MS;
  localparam int TW     = (TO_CYC < 1) ? 1 : $clog2(TO_CYC + 1);
  localparam int RW     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TO_CYC);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ERROR  = 8'hFC;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RSP, FINISH} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    cmd_reg, cmd_next;
  logic          owner_reg, owner_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          first_reg, first_next;
  logic          acc0_reg, acc0_next, acc1_reg, acc1_next;
  logic          done0_reg, done0_next, done1_reg, done1_next;
  logic          err0_reg, err0_next, err1_reg, err1_next;
  logic          tx_start_reg, tx_start_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          fwd_valid_reg, fwd_valid_next;
  logic [7:0]    fwd_data_reg, fwd_data_next;

  logic          grant0, grant1;
  logic          finish, fail;
  logic          expired;
  logic [TW-1:0] timer_dec;

`ifdef PS2_SCHED_RR_EN
  logic last_reg, last_next;  // 1: req1 holds the most recent grant
  assign grant1    = req1 && (!req0 || !last_reg);
  assign last_next = (state_reg == IDLE && (grant0 || grant1)) ? grant1 : last_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_reg <= 1'b1;
    else        last_reg <= last_next;
  end
`else
  assign grant1 = req1 && !req0;
`endif
  assign grant0 = req0 && !grant1;

  // The timer expires on the cycle it would step from 1 to 0; it never wraps.
  assign expired   = (timer_reg <= TW'(1));
  assign timer_dec = (timer_reg != '0) ? timer_reg - TW'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cmd_reg       <= '0;
      owner_reg     <= 1'b0;
      retry_reg     <= '0;
      timer_reg     <= '0;
      first_reg     <= 1'b0;
      acc0_reg      <= 1'b0;
      acc1_reg      <= 1'b0;
      done0_reg     <= 1'b0;
      done1_reg     <= 1'b0;
      err0_reg      <= 1'b0;
      err1_reg      <= 1'b0;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= '0;
      fwd_valid_reg <= 1'b0;
      fwd_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cmd_reg       <= cmd_next;
      owner_reg     <= owner_next;
      retry_reg     <= retry_next;
      timer_reg     <= timer_next;
      first_reg     <= first_next;
      acc0_reg      <= acc0_next;
      acc1_reg      <= acc1_next;
      done0_reg     <= done0_next;
      done1_reg     <= done1_next;
      err0_reg      <= err0_next;
      err1_reg      <= err1_next;
      tx_start_reg  <= tx_start_next;
      tx_data_reg   <= tx_data_next;
      fwd_valid_reg <= fwd_valid_next;
      fwd_data_reg  <= fwd_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cmd_next       = cmd_reg;
    owner_next     = owner_reg;
    retry_next     = retry_reg;
    timer_next     = timer_reg;
    first_next     = first_reg;
    acc0_next      = 1'b0;
    acc1_next      = 1'b0;
    done0_next     = 1'b0;
    done1_next     = 1'b0;
    err0_next      = 1'b0;
    err1_next      = 1'b0;
    tx_start_next  = 1'b0;
    tx_data_next   = tx_data_reg;
    fwd_valid_next = rx_valid;
    fwd_data_next  = rx_valid ? rx_data : fwd_data_reg;
    finish         = 1'b0;
    fail           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant0 || grant1) begin
          acc0_next  = grant0;
          acc1_next  = grant1;
          cmd_next   = grant0 ? data0 : data1;
          owner_next = grant1;
          retry_next = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        tx_start_next = 1'b1;
        tx_data_next  = cmd_reg;
        timer_next    = TO_LOAD;
        first_next    = 1'b1;
        state_next    = WAIT_TX;
      end
      WAIT_TX: begin
        // tx_busy may still be low on the first cycle after tx_start.
        first_next = 1'b0;
        if (!first_reg && !tx_busy) begin
          timer_next = TO_LOAD;
          state_next = WAIT_RSP;
        end else if (expired) begin
          finish = 1'b1;
          fail   = 1'b1;
        end else begin
          timer_next = timer_dec;
        end
      end
      WAIT_RSP: begin
        timer_next = timer_dec;
        if (rx_valid && rx_data == RSP_ACK) begin
          fwd_valid_next = 1'b0;
          finish         = 1'b1;
        end else if (rx_valid && rx_data == RSP_RESEND) begin
          fwd_valid_next = 1'b0;
          if (retry_reg < RETRY_MAX) begin
            retry_next = retry_reg + RW'(1);
            state_next = SEND;
          end else begin
            finish = 1'b1;
            fail   = 1'b1;
          end
        end else if (rx_valid && rx_data == RSP_ERROR) begin
          fwd_valid_next = 1'b0;
          finish         = 1'b1;
          fail           = 1'b1;
        end else if (expired && !rx_valid) begin
          finish = 1'b1;
          fail   = 1'b1;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Result strobes are registered so they appear during the FINISH cycle.
    if (finish) begin
      state_next = FINISH;
      done0_next = !owner_reg;
      done1_next = owner_reg;
      err0_next  = fail && !owner_reg;
      err1_next  = fail && owner_reg;
    end
  end

  assign acc0      = acc0_reg;
  assign acc1      = acc1_reg;
  assign done0     = done0_reg;
  assign done1     = done1_reg;
  assign err0      = err0_reg;
  assign err1      = err1_reg;
  assign tx_start  = tx_start_reg;
  assign tx_data   = tx_data_reg;
  assign fwd_valid = fwd_valid_reg;
  assign fwd_data  = fwd_data_reg;
  assign busy      = (state_reg != IDLE);

endmodule
